// File: rtl/axil_master_if.sv
// axil_master_if: single-outstanding AXI4-Lite initiator.
// Turns a command/response handshake into one AXI4-Lite write (AW/W/B) or
// read (AR/R) at a time and returns resp code and read data.
// Optional build macro AXIL_MASTER_TIMEOUT_EN adds a sticky err_timeout
// watchdog flag; the transaction itself is never aborted.
module axil_master_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
`ifdef AXIL_MASTER_TIMEOUT_EN
  ,
  output logic                  err_timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic aw_done_q, w_done_q;
  logic cmd_accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign aw_hs      = m_axil_awvalid && m_axil_awready;
  assign w_hs       = m_axil_wvalid && m_axil_wready;
  assign b_hs       = m_axil_bvalid && m_axil_bready;
  assign ar_hs      = m_axil_arvalid && m_axil_arready;
  assign r_hs       = m_axil_rvalid && m_axil_rready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    m_axil_bready = 1'b0;
    m_axil_rready = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) state_d = cmd_we ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        // AW and W complete independently; leave once both are done
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) state_d = RSP;
      end
      RD_REQ: begin
        if (ar_hs) state_d = RD_RESP;
      end
      RD_RESP: begin
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request channel registers and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      rsp_we         <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= 2'b00;
    end else begin
      if (cmd_accept) begin
        rsp_we <= cmd_we;
        if (cmd_we) begin
          m_axil_awaddr  <= cmd_addr;
          m_axil_wdata   <= cmd_wdata;
          m_axil_wstrb   <= cmd_wstrb;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid  <= 1'b1;
          aw_done_q      <= 1'b0;
          w_done_q       <= 1'b0;
        end else begin
          m_axil_araddr  <= cmd_addr;
          m_axil_arvalid <= 1'b1;
        end
      end
      if (aw_hs) begin
        m_axil_awvalid <= 1'b0;
        aw_done_q      <= 1'b1;
      end
      if (w_hs) begin
        m_axil_wvalid <= 1'b0;
        w_done_q      <= 1'b1;
      end
      if (ar_hs) m_axil_arvalid <= 1'b0;
      if (b_hs) begin
        rsp_resp  <= m_axil_bresp;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_resp  <= m_axil_rresp;
        rsp_rdata <= m_axil_rdata;
      end
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             waiting;

  assign waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_RESP);

  // Watchdog: counts cycles spent waiting on the responder, flag is sticky
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      err_timeout <= 1'b0;
    end else if (cmd_accept) begin
      wait_cnt_q <= '0;
    end else if (waiting) begin
      if (wait_cnt_q != CNT_W'(TIMEOUT_CYCLES)) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) err_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_master_if.sv
// Bench for axil_master_if: table of commands against a configurable
// AXI4-Lite responder model, scoreboard of expected responses, plus
// hand-written stall, error-resp, timeout and mid-transaction reset cases.
module tb_axil_master_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] m_axil_awaddr, m_axil_araddr;
  logic        m_axil_awvalid, m_axil_awready;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready;
  logic        m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic        err_timeout;
`endif

  always #5 clk = ~clk;

  axil_master_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready)
`ifdef AXIL_MASTER_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  // ---------------- responder model ----------------
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  bit          early_b = 1'b0;
  logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  bit          got_aw, got_w, r_pending;
  logic [15:0] cap_awaddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  int          b_hs_count, ar_hs_count;
  logic [31:0] mem [0:15];

  assign m_axil_awready = m_axil_awvalid && (aw_cnt >= aw_wait);
  assign m_axil_wready  = m_axil_wvalid && (w_cnt >= w_wait);
  assign m_axil_arready = m_axil_arvalid && (ar_cnt >= ar_wait);
  assign m_axil_bresp   = b_resp_k;

  // Responder: delayed readies, optional early bvalid, memory backing store
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; r_pending <= 1'b0;
      m_axil_bvalid <= 1'b0; m_axil_rvalid <= 1'b0;
      m_axil_rdata <= '0; m_axil_rresp <= 2'b00;
      cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else begin
      if (m_axil_awvalid && m_axil_awready) begin
        got_aw <= 1'b1; cap_awaddr <= m_axil_awaddr; aw_cnt <= 0;
      end else if (m_axil_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_axil_wvalid && m_axil_wready) begin
        got_w <= 1'b1; cap_wdata <= m_axil_wdata; cap_wstrb <= m_axil_wstrb; w_cnt <= 0;
      end else if (m_axil_wvalid) w_cnt <= w_cnt + 1;
      if (!m_axil_bvalid && (got_w || (m_axil_wvalid && m_axil_wready)) &&
          (early_b || got_aw || (m_axil_awvalid && m_axil_awready)))
        m_axil_bvalid <= 1'b1;
      if (m_axil_bvalid && m_axil_bready) begin
        m_axil_bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
        b_hs_count <= b_hs_count + 1;
        for (int i = 0; i < 4; i++)
          if (cap_wstrb[i]) mem[cap_awaddr[5:2]][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
      if (m_axil_arvalid && m_axil_arready) begin
        ar_hs_count <= ar_hs_count + 1;
        m_axil_rdata <= mem[m_axil_araddr[5:2]];
        m_axil_rresp <= r_resp_k;
        ar_cnt <= 0; r_cnt <= 0;
        if (r_wait == 0) m_axil_rvalid <= 1'b1;
        else r_pending <= 1'b1;
      end else if (m_axil_arvalid) ar_cnt <= ar_cnt + 1;
      if (r_pending) begin
        if (r_cnt + 1 >= r_wait) begin m_axil_rvalid <= 1'b1; r_pending <= 1'b0; end
        else r_cnt <= r_cnt + 1;
      end
      if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  typedef struct { logic we; logic [31:0] rdata; logic [1:0] resp; } exp_t;
  typedef struct {
    logic we; logic [15:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] exp_rd; logic [31:0] exp_mem;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0, failures = 0;
  int   mon_err, awv_cycles, wv_cycles, bwait_cycles, rsp_lat, to_first_k;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one command, watch the AXI side every cycle, collect the response
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int rsp_delay, input bit pulse_cmd,
                         input logic [1:0] exp_resp, input logic [31:0] exp_rd);
    exp_t e;
    int   k, stall, guard;
    bit   got, pulsed, aw_pend, w_pend, ar_pend, aw_hs_p, w_hs_p, ar_hs_p;
    logic snap_we;
    logic [31:0] snap_rd;
    logic [1:0]  snap_resp;
    mon_err = 0; awv_cycles = 0; wv_cycles = 0; bwait_cycles = 0; rsp_lat = 0; to_first_k = 0;
    snap_we = 1'b0; snap_rd = '0; snap_resp = 2'b00;
    cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    e.we = we; e.rdata = exp_rd; e.resp = exp_resp;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("axi_valid_next_cycle",
        64'(we ? (m_axil_awvalid & m_axil_wvalid & ~m_axil_arvalid)
               : (m_axil_arvalid & ~m_axil_awvalid & ~m_axil_wvalid)), 64'd1);
    k = 1; stall = 0; got = 0; pulsed = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0;
    while (!got && k < 200) begin
      if (cmd_ready) mon_err++;
      if (aw_pend && (!m_axil_awvalid || m_axil_awaddr !== addr)) mon_err++;
      if (w_pend && (!m_axil_wvalid || m_axil_wdata !== wd || m_axil_wstrb !== ws)) mon_err++;
      if (ar_pend && (!m_axil_arvalid || m_axil_araddr !== addr)) mon_err++;
      if ((aw_hs_p && m_axil_awvalid) || (w_hs_p && m_axil_wvalid) || (ar_hs_p && m_axil_arvalid))
        mon_err++;
      aw_pend = m_axil_awvalid && !m_axil_awready;  aw_hs_p = m_axil_awvalid && m_axil_awready;
      w_pend  = m_axil_wvalid && !m_axil_wready;    w_hs_p  = m_axil_wvalid && m_axil_wready;
      ar_pend = m_axil_arvalid && !m_axil_arready;  ar_hs_p = m_axil_arvalid && m_axil_arready;
      if (m_axil_awvalid) awv_cycles++;
      if (m_axil_wvalid) wv_cycles++;
      if (m_axil_bvalid && !m_axil_bready) bwait_cycles++;
`ifdef AXIL_MASTER_TIMEOUT_EN
      if (err_timeout && to_first_k == 0) to_first_k = k;
`endif
      cmd_valid = 1'b0;
      if (pulse_cmd && !pulsed && m_axil_rready) begin
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = addr ^ 16'h0004; pulsed = 1;
      end
      if (rsp_valid) begin
        if (stall == 0) begin
          rsp_lat = k; snap_we = rsp_we; snap_rd = rsp_rdata; snap_resp = rsp_resp;
        end else if (rsp_we !== snap_we || rsp_rdata !== snap_rd || rsp_resp !== snap_resp)
          mon_err++;
        if (stall >= rsp_delay) begin
          rsp_ready = 1'b1;
          @(negedge clk);
          rsp_ready = 1'b0;
          got = 1;
        end else stall++;
      end
      if (!got) begin @(negedge clk); k++; end
    end
    cmd_valid = 1'b0;
    chk("rsp_arrived", 64'(got), 64'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_we", 64'(snap_we), 64'(e.we));
      chk("rsp_rdata", 64'(snap_rd), 64'(e.rdata));
      chk("rsp_resp", 64'(snap_resp), 64'(e.resp));
      chk("rsp_valid_drops", 64'(rsp_valid), 64'd0);
      chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
    end else sb.delete();
    chk("protocol_monitor", 64'(mon_err), 64'd0);
  endtask

  initial begin
    int b0, a0;
    vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 16'h0010, 32'h0000AA00, 4'h2, 32'h0, 32'hDEADAAEF};
    vecs[3] = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADAAEF, 32'hDEADAAEF};
    vecs[4] = '{1'b1, 16'h0014, 32'h12345678, 4'h9, 32'h0, 32'h12000078};
    vecs[5] = '{1'b0, 16'h0014, 32'h0,        4'h0, 32'h12000078, 32'h12000078};
    vecs[6] = '{1'b0, 16'h0018, 32'h0,        4'h0, 32'hA5000006, 32'hA5000006};
    vecs[7] = '{1'b1, 16'h003C, 32'hFFFFFFFF, 4'hF, 32'h0, 32'hFFFFFFFF};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    b_hs_count = 0; ar_hs_count = 0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
                             m_axil_rready, rsp_valid}), 64'd0);
    chk("reset_data", 64'({m_axil_awaddr, m_axil_araddr, m_axil_wstrb}) | 64'(m_axil_wdata), 64'd0);
    chk("reset_rsp", 64'({rsp_we, rsp_resp}) | 64'(rsp_rdata), 64'd0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("reset_err_timeout", 64'(err_timeout), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table of zero-wait transactions
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 1'b0, 2'b00, vecs[i].exp_rd);
      chk("rsp_latency", 64'(rsp_lat), 64'd3);
      if (vecs[i].we) begin
        chk("awaddr_on_hs", 64'(cap_awaddr), 64'(vecs[i].addr));
        chk("wdata_on_hs", 64'(cap_wdata), 64'(vecs[i].wdata));
      end
      chk("mem_word", 64'(mem[vecs[i].addr[5:2]]), 64'(vecs[i].exp_mem));
    end

    // AW late by 3 cycles, W immediate, bvalid raised early, rsp stalled 4 cycles
    aw_wait = 3; early_b = 1'b1; b0 = b_hs_count;
    run_txn(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 4, 1'b0, 2'b00, 32'h0);
    chk("stall_awvalid_cycles", 64'(awv_cycles), 64'd4);
    chk("stall_wvalid_cycles", 64'(wv_cycles), 64'd1);
    chk("stall_early_bvalid_unacked", 64'(bwait_cycles), 64'd3);
    chk("stall_one_b_hs", 64'(b_hs_count - b0), 64'd1);
    chk("stall_mem_word", 64'(mem[8]), 64'hCAFEF00D);
    aw_wait = 0; early_b = 1'b0;

    // W late, AW immediate; DECERR on B passed through
    w_wait = 2; b_resp_k = 2'b11;
    run_txn(1'b1, 16'h0024, 32'h00000001, 4'hF, 0, 1'b0, 2'b11, 32'h0);
    chk("wlate_awvalid_cycles", 64'(awv_cycles), 64'd1);
    chk("wlate_wvalid_cycles", 64'(wv_cycles), 64'd3);
    w_wait = 0; b_resp_k = 2'b00;

    // SLVERR on R, with a stray cmd_valid pulse while waiting for R
    r_resp_k = 2'b10; r_wait = 3; a0 = ar_hs_count;
    run_txn(1'b0, 16'h0010, 32'h0, 4'h0, 0, 1'b1, 2'b10, 32'hDEADAAEF);
    chk("slverr_single_ar", 64'(ar_hs_count - a0), 64'd1);
    r_resp_k = 2'b00; r_wait = 0;

`ifdef AXIL_MASTER_TIMEOUT_EN
    // arready held 20 cycles: counter equals k after cycle k, flag visible from cycle 9
    ar_wait = 20;
    run_txn(1'b0, 16'h0020, 32'h0, 4'h0, 0, 1'b0, 2'b00, 32'hCAFEF00D);
    chk("timeout_first_cycle", 64'(to_first_k), 64'd9);
    chk("timeout_sticky", 64'(err_timeout), 64'd1);
`endif

    // Reset in the middle of a stalled read
    ar_wait = 20;
    cmd_we = 1'b0; cmd_addr = 16'h0010; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_arvalid_before", 64'(m_axil_arvalid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
                              m_axil_rready, rsp_valid, cmd_ready}), 64'd0);
    chk("midrst_araddr", 64'(m_axil_araddr), 64'd0);
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("midrst_err_timeout", 64'(err_timeout), 64'd0);
`endif
    rst_n = 1'b1; ar_wait = 0;
    @(negedge clk);
    run_txn(1'b0, 16'h0010, 32'h0, 4'h0, 0, 1'b0, 2'b00, 32'hA5000004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
